// File: rtl/pio_pwm_bank.sv
// PWM bank driven by a toggle-committed command word from a software GPIO port.
// Duty changes are double-buffered and only take effect at a period wrap.
module pio_pwm_bank #(
  parameter int NUM_CH  = 8,
  parameter int PRESC_W = 16
) (
  input  logic              clk_in_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       cmd_word,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cmd_ack,
  output logic              period_tick,
  output logic              err
);

  localparam logic [4:0] NCH = 5'(NUM_CH);

  logic [31:0]        cmd_q;
  logic               last_tog;
  logic [7:0]         shadow [NUM_CH];
  logic [7:0]         active [NUM_CH];
  logic [NUM_CH-1:0]  en;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] div;
  logic [7:0]         cnt;

  logic        commit;
  logic [2:0]  op;
  logic [3:0]  ch;
  logic [15:0] data;
  logic        ch_ok;
  logic        step;
  logic        wrap;
  logic        do_duty;
  logic        do_presc;
  logic        do_en;
  logic        do_clr;
  logic        do_bad;
  logic        unused_bits;

  assign commit = cmd_q[31] ^ last_tog;
  assign op     = cmd_q[30:28];
  assign ch     = cmd_q[27:24];
  assign data   = cmd_q[15:0];
  assign ch_ok  = {1'b0, ch} < NCH;

  assign unused_bits = ^{cmd_q[23:16], data};

  // >= lets a prescaler lowered below the running count recover at once
  assign step = div >= presc;
  assign wrap = step && (cnt == 8'hff);

  assign do_duty  = commit && (op == 3'd0) && ch_ok;
  assign do_presc = commit && (op == 3'd1);
  assign do_en    = commit && (op == 3'd2);
  assign do_clr   = commit && (op == 3'd3);
  assign do_bad   = commit && !(do_duty || do_presc
                                || do_en || do_clr);

  always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_q       <= '0;
      last_tog    <= 1'b0;
      cmd_ack     <= 1'b0;
      err         <= 1'b0;
      en          <= '0;
      presc       <= '0;
      div         <= '0;
      cnt         <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      cmd_q       <= cmd_word;
      period_tick <= wrap;

      for (int i = 0; i < NUM_CH; i++)
        pwm_out[i] <= en[i] && (cnt < active[i]);

      if (step) begin
        div <= '0;
        cnt <= cnt + 8'd1;
      end else begin
        div <= div + 1'b1;
      end

      // write-through keeps a duty committed on the wrap edge
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrap)
          active[i] <= shadow[i];
        if (do_duty && ch == 4'(i)) begin
          shadow[i] <= data[7:0];
          if (wrap)
            active[i] <= data[7:0];
        end
      end

      if (commit) begin
        last_tog <= cmd_q[31];
        cmd_ack  <= cmd_q[31];
      end

      unique case (1'b1)
        do_presc: begin
          presc <= data[PRESC_W-1:0];
          div   <= '0;
        end
        do_en:   en  <= data[NUM_CH-1:0];
        do_clr:  err <= 1'b0;
        do_bad:  err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_pwm_bank.sv
// Bench for pio_pwm_bank: command table, corner sequences and random
// traffic compared every cycle against a behavioural model.
module tb_pio_pwm_bank;

  localparam int NUM_CH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       cmd_word = '0;
  logic [NUM_CH-1:0] pwm_out;
  logic              cmd_ack;
  logic              period_tick;
  logic              err;

  always #5 clk = ~clk;

  pio_pwm_bank #(.NUM_CH(NUM_CH), .PRESC_W(16)) dut (
    .clk_in_clk   (clk),
    .reset_reset_n(rst_n),
    .cmd_word     (cmd_word),
    .pwm_out      (pwm_out),
    .cmd_ack      (cmd_ack),
    .period_tick  (period_tick),
    .err          (err)
  );

  int n_pass = 0;
  int n_chk  = 0;
  bit tog    = 1'b0;
  bit mon    = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // behavioural model: period position, duty buffers, command pipe
  logic [31:0]       m_q;
  logic              m_tog, m_ack, m_err, m_tick;
  logic [NUM_CH-1:0] m_pwm, m_en;
  int                m_sh [NUM_CH];
  int                m_ac [NUM_CH];
  int                m_presc, m_div, m_cnt;

  task automatic model_reset();
    m_q = 0; m_tog = 0; m_ack = 0; m_err = 0; m_tick = 0;
    m_pwm = 0; m_en = 0; m_presc = 0; m_div = 0; m_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_sh[i] = 0;
      m_ac[i] = 0;
    end
  endtask

  task automatic model_step();
    bit stp, wr;
    int op, ch, d;
    stp = m_div >= m_presc;
    wr  = stp && (m_cnt == 255);
    for (int i = 0; i < NUM_CH; i++)
      m_pwm[i] = m_en[i] && (m_cnt < m_ac[i]);
    m_tick = wr;
    if (wr)
      for (int i = 0; i < NUM_CH; i++) m_ac[i] = m_sh[i];
    if (stp) begin
      m_div = 0;
      m_cnt = (m_cnt + 1) % 256;
    end else begin
      m_div = m_div + 1;
    end
    if (m_q[31] != m_tog) begin
      op = int'(m_q[30:28]);
      ch = int'(m_q[27:24]);
      d  = int'(m_q[15:0]);
      m_tog = m_q[31];
      m_ack = m_q[31];
      case (op)
        0: if (ch < NUM_CH) begin
             m_sh[ch] = d % 256;
             if (wr) m_ac[ch] = d % 256;
           end else m_err = 1;
        1: begin m_presc = d; m_div = 0; end
        2: m_en = NUM_CH'(d);
        3: m_err = 0;
        default: m_err = 1;
      endcase
    end
    m_q = cmd_word;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (mon && rst_n) begin
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("cmd_ack", 32'(cmd_ack), 32'(m_ack));
      check("period_tick", 32'(period_tick), 32'(m_tick));
      check("err", 32'(err), 32'(m_err));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(logic [2:0] op, logic [3:0] ch, logic [15:0] d);
    tog = ~tog;
    cmd_word = {tog, op, ch, 8'h00, d};
  endtask

  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (period_tick) begin ok = 1; break; end
    end
  endtask

  task automatic tick_gap(output int gap);
    gap = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      gap++;
      if (period_tick) break;
    end
  endtask

  task automatic count_hi(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  ch;
    logic [15:0] d;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bit ok;
    int hi, gap;

    tbl[0] = '{3'd1, 4'd0,  16'd0,    1'b0};
    tbl[1] = '{3'd2, 4'd0,  16'h0001, 1'b0};
    tbl[2] = '{3'd0, 4'd0,  16'd64,   1'b0};
    tbl[3] = '{3'd7, 4'd0,  16'd5,    1'b1};
    tbl[4] = '{3'd0, 4'd12, 16'd99,   1'b1};
    tbl[5] = '{3'd3, 4'd0,  16'd0,    1'b0};
    tbl[6] = '{3'd0, 4'd9,  16'd7,    1'b1};
    tbl[7] = '{3'd3, 4'd0,  16'd0,    1'b0};

    #12;
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_ack", 32'(cmd_ack), 0);
    check("rst_tick", 32'(period_tick), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon = 1'b1;

    for (int k = 0; k < 8; k++) begin
      send(tbl[k].op, tbl[k].ch, tbl[k].d);
      cyc(1);
      check("ack_early", 32'(cmd_ack), 32'(!tog));
      cyc(1);
      check("ack_lat2", 32'(cmd_ack), 32'(tog));
      check("tbl_err", 32'(err), 32'(tbl[k].exp_err));
      cyc(2);
    end

    wait_tick(ok);
    check("tick_seen", 32'(ok), 1);
    count_hi(256, hi);
    check("duty64", hi, 64);
    wait_tick(ok);
    tick_gap(gap);
    check("period256", gap, 256);

    // data change without toggle must never commit
    cmd_word = {tog, 3'd0, 4'd0, 8'h00, 16'd10};
    cyc(1000);
    check("hold_ack", 32'(cmd_ack), 32'(tog));
    wait_tick(ok);
    count_hi(256, hi);
    check("hold_duty", hi, 64);

    wait_tick(ok);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      if (i == 50) send(3'd0, 4'd0, 16'd200);
    end
    check("mid_keep64", hi, 64);
    count_hi(256, hi);
    check("next200", hi, 200);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (m_cnt == 254) break;
    end
    send(3'd0, 4'd0, 16'd128);
    wait_tick(ok);
    count_hi(256, hi);
    check("wrap_wt128", hi, 128);

    send(3'd0, 4'd0, 16'd0);
    wait_tick(ok);
    count_hi(256, hi);
    check("duty0", hi, 0);
    send(3'd0, 4'd0, 16'd255);
    wait_tick(ok);
    count_hi(256, hi);
    check("duty255", hi, 255);

    send(3'd1, 4'd0, 16'd3);
    wait_tick(ok);
    tick_gap(gap);
    check("period1024", gap, 1024);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_div == 1) break;
    end
    send(3'd1, 4'd0, 16'd0);
    wait_tick(ok);
    check("presc_nolock", 32'(ok), 1);
    tick_gap(gap);
    check("period_back", gap, 256);

    for (int r = 0; r < 150; r++) begin
      logic [2:0] op;
      logic [15:0] d;
      op = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      if (op == 3'd1) d = 16'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0)
        cmd_word[15:0] = d;
      else
        send(op, 4'($urandom_range(0, 11)), d);
      cyc($urandom_range(2, 40));
    end

    send(3'd1, 4'd0, 16'd0);    cyc(4);
    send(3'd2, 4'd0, 16'h00ff); cyc(4);
    send(3'd0, 4'd0, 16'd255);  cyc(4);
    wait_tick(ok);
    cyc(20);
    #2;
    check("pre_rst_hi", 32'(pwm_out[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async_pwm", 32'(pwm_out), 0);
    check("async_ack", 32'(cmd_ack), 0);
    check("async_err", 32'(err), 0);
    check("async_tick", 32'(period_tick), 0);
    tog = 1'b0;
    cmd_word = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(300);
    check("post_rst_low", 32'(pwm_out), 0);

    mon = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
